// File: rtl/mem_pkg.sv
// Shared definitions for the burst master and its memory responder.
// Provides default geometry (word width, depth, address width), the
// burst-master state encoding and the command direction constants.
package mem_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_ADDR  = $clog2(DEF_DEPTH);

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REQ,
    ST_PUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port valid/ready memory.
// Accepts one command (start address, length, direction) and moves that many
// words between the memory and a stream, one outstanding request at a time.
//
// Ports:
//   clk_i, rst_i                    clock, async active-high reset
//   cmd_valid_i/cmd_ready_o         command handshake (ready only when idle)
//   cmd_wr_i, cmd_addr_i, cmd_len_i direction, start address, word count
//   s_data_i/s_valid_i/s_ready_o    write-data input stream
//   m_data_o/m_valid_o/m_ready_i    read-data output stream
//   mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o  memory request
//   mem_rdata_i, mem_ready_i        memory response
//   busy_o, done_o                  burst active, one-cycle completion pulse
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_wr_i,
  input  logic [ADDR-1:0]  cmd_addr_i,
  input  logic [ADDR:0]    cmd_len_i,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             mem_valid_o,
  output logic             mem_wr_rd_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  input  logic             mem_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  state_t           state_q, state_d;
  logic [ADDR-1:0]  addr_q;
  logic [ADDR:0]    cnt_q;
  logic             wr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;

  // Requests longer than the memory are limited to one full pass.
  function automatic logic [ADDR:0] clamp_len(input logic [ADDR:0] len);
    if (len > (ADDR+1)'(DEPTH)) return (ADDR+1)'(DEPTH);
    return len;
  endfunction

  // Address increment that wraps at DEPTH-1 even for non power-of-two depths.
  function automatic logic [ADDR-1:0] next_addr(input logic [ADDR-1:0] a);
    if (a == ADDR'(DEPTH - 1)) return '0;
    return a + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          if (clamp_len(cmd_len_i) == '0) state_d = ST_DONE;
          else if (cmd_wr_i == CMD_WR)    state_d = ST_FETCH;
          else                            state_d = ST_REQ;
        end
      end
      ST_FETCH: if (s_valid_i) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_ready_i) begin
          if (wr_q == CMD_WR)
            state_d = (cnt_q == (ADDR+1)'(1)) ? ST_DONE : ST_FETCH;
          else
            state_d = ST_PUSH;
        end
      end
      // cnt_q was already decremented when the word was read.
      ST_PUSH: if (m_ready_i) state_d = (cnt_q == '0) ? ST_DONE : ST_REQ;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= CMD_RD;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            addr_q <= cmd_addr_i;
            cnt_q  <= clamp_len(cmd_len_i);
            wr_q   <= cmd_wr_i;
          end
        end
        ST_FETCH: if (s_valid_i) wdata_q <= s_data_i;
        ST_REQ: begin
          if (mem_ready_i) begin
            addr_q <= next_addr(addr_q);
            cnt_q  <= cnt_q - 1'b1;
            if (wr_q == CMD_RD) rdata_q <= mem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Every output is either a register or a decode of state_q, so nothing
  // here is combinationally dependent on an input.
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign s_ready_o   = (state_q == ST_FETCH);
  assign mem_valid_o = (state_q == ST_REQ);
  assign mem_wr_rd_o = (state_q == ST_REQ) && wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign m_valid_o   = (state_q == ST_PUSH);
  assign m_data_o    = rdata_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: memory responder with programmable wait,
// write-data source, read-data sink with optional toggling ready, and a
// table of burst vectors plus hand-written corner-case sequences.
module tb_mem_burst_master;

  localparam int W = 16;
  localparam int D = 64;
  localparam int A = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid_i = 1'b0;
  logic         cmd_ready_o;
  logic         cmd_wr_i = 1'b0;
  logic [A-1:0] cmd_addr_i = '0;
  logic [A:0]   cmd_len_i = '0;
  logic [W-1:0] s_data_i;
  logic         s_valid_i;
  logic         s_ready_o;
  logic [W-1:0] m_data_o;
  logic         m_valid_o;
  logic         m_ready_i = 1'b0;
  logic         mem_valid_o;
  logic         mem_wr_rd_o;
  logic [A-1:0] mem_addr_o;
  logic [W-1:0] mem_wdata_o;
  logic [W-1:0] mem_rdata_i;
  logic         mem_ready_i;
  logic         busy_o;
  logic         done_o;

  mem_burst_master #(.WIDTH(W), .DEPTH(D), .ADDR(A)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Environment knobs written by the test sequence.
  int dly = 0;
  bit tog = 1'b0;
  int src_base = 0, src_off = 0, src_end = 0;

  // State owned by the monitor/responder processes.
  logic [W-1:0] mem [D];
  int wait_cnt = 0;
  int src_idx = 0;
  int done_cnt = 0;
  int mv_cycles = 0;
  int viol = 0;
  int addr_log[$];
  int rx_q[$];
  logic         prev_mv = 1'b0, prev_mr = 1'b0, prev_wr = 1'b0;
  logic [A-1:0] prev_addr = '0;
  logic [W-1:0] prev_wd = '0, prev_md = '0;
  logic         prev_sv = 1'b0, prev_sr = 1'b0;

  assign mem_ready_i = mem_valid_o && (wait_cnt >= dly);
  assign mem_rdata_i = mem[mem_addr_o];
  assign s_valid_i   = (src_idx < src_end);
  assign s_data_i    = W'(src_base + (src_idx - src_off));

  always @(posedge clk or posedge rst) begin
    if (rst)                              wait_cnt <= 0;
    else if (mem_valid_o && !mem_ready_i) wait_cnt <= wait_cnt + 1;
    else                                  wait_cnt <= 0;
  end

  always @(negedge clk) m_ready_i <= tog ? ~m_ready_i : 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      prev_mv <= 1'b0;
      prev_sv <= 1'b0;
    end else begin
      if (s_valid_i && s_ready_o) src_idx <= src_idx + 1;
      if (mem_valid_o) mv_cycles <= mv_cycles + 1;
      if (mem_valid_o && mem_ready_i) begin
        addr_log.push_back(int'(mem_addr_o));
        if (mem_wr_rd_o) mem[mem_addr_o] <= mem_wdata_o;
      end
      if (m_valid_o && m_ready_i) rx_q.push_back(int'(m_data_o));
      if (done_o) done_cnt <= done_cnt + 1;
      if (prev_mv && !prev_mr &&
          (!mem_valid_o || mem_addr_o != prev_addr || mem_wdata_o != prev_wd ||
           mem_wr_rd_o != prev_wr))
        viol <= viol + 1;
      if (prev_sv && !prev_sr && (!m_valid_o || m_data_o != prev_md))
        viol <= viol + 1;
      prev_mv <= mem_valid_o; prev_mr <= mem_ready_i; prev_wr <= mem_wr_rd_o;
      prev_addr <= mem_addr_o; prev_wd <= mem_wdata_o;
      prev_sv <= m_valid_o; prev_sr <= m_ready_i; prev_md <= m_data_o;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_cmd_ready"}, int'(cmd_ready_o), 1);
    chk({nm, "_others"}, int'({s_ready_o, m_valid_o, mem_valid_o, mem_wr_rd_o,
                                busy_o, done_o}), 0);
    chk({nm, "_buses"}, int'({m_data_o, mem_wdata_o, 4'd0, mem_addr_o}), 0);
  endtask

  typedef struct {
    bit wr;
    int addr;
    int len;
    int exp_len;
    int base;
    int dly;
    bit tog;
  } vec_t;

  task automatic run_burst(input vec_t v);
    int rx0, al0, dn0, vi0;
    bit seen, busy_bad;
    rx0 = rx_q.size(); al0 = addr_log.size(); dn0 = done_cnt; vi0 = viol;
    dly = v.dly; tog = v.tog;
    if (v.wr) begin
      src_base = v.base; src_off = src_idx; src_end = src_idx + v.exp_len;
    end
    @(negedge clk);
    chk("cmd_ready_idle", int'(cmd_ready_o), 1);
    cmd_valid_i = 1'b1; cmd_wr_i = v.wr;
    cmd_addr_i = A'(v.addr); cmd_len_i = (A+1)'(v.len);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    seen = 1'b0; busy_bad = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (!busy_o) busy_bad = 1'b1;
      if (done_o) seen = 1'b1;
    end
    chk("done_seen", int'(seen), 1);
    @(posedge clk); #1;
    tog = 1'b0;
    chk("busy_throughout", int'(busy_bad), 0);
    chk("done_once", done_cnt - dn0, 1);
    chk("stable_when_stalled", viol - vi0, 0);
    chk("mem_requests", addr_log.size() - al0, v.exp_len);
    if (addr_log.size() - al0 == v.exp_len)
      for (int i = 0; i < v.exp_len; i++)
        chk($sformatf("addr[%0d]", i), addr_log[al0 + i], (v.addr + i) % D);
    if (v.wr) begin
      for (int i = 0; i < v.exp_len; i++)
        chk($sformatf("mem[%0d]", (v.addr + i) % D), int'(mem[(v.addr + i) % D]),
            (v.base + i) & 16'hFFFF);
    end else begin
      chk("rx_count", rx_q.size() - rx0, v.exp_len);
      if (rx_q.size() - rx0 == v.exp_len)
        for (int i = 0; i < v.exp_len; i++)
          chk($sformatf("rx[%0d]", i), rx_q[rx0 + i], v.base + i);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int mv0, dn0, al0, lat;
    bit seen;

    vecs[0] = '{wr:1, addr:10, len:10,  exp_len:10, base:16'h0001, dly:0, tog:0};
    vecs[1] = '{wr:0, addr:10, len:10,  exp_len:10, base:16'h0001, dly:0, tog:0};
    vecs[2] = '{wr:1, addr:62, len:4,   exp_len:4,  base:16'h00A0, dly:0, tog:0};
    vecs[3] = '{wr:1, addr:20, len:5,   exp_len:5,  base:16'h0100, dly:3, tog:0};
    vecs[4] = '{wr:0, addr:20, len:5,   exp_len:5,  base:16'h0100, dly:3, tog:1};
    vecs[5] = '{wr:0, addr:62, len:4,   exp_len:4,  base:16'h00A0, dly:1, tog:1};
    vecs[6] = '{wr:1, addr:0,  len:100, exp_len:64, base:16'h0200, dly:0, tog:0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i]) run_burst(vecs[i]);

    // Read back part of the clamped full-memory write: mem[a] = 0x200 + a.
    run_burst('{wr:0, addr:5, len:3, exp_len:3, base:16'h0205, dly:0, tog:0});

    // len=0: completes without touching memory.
    mv0 = mv_cycles; dn0 = done_cnt;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = 6'd7; cmd_len_i = '0;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    lat = 1; seen = done_o;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk); #1;
      lat++;
      seen = done_o;
    end
    chk("len0_done_seen", int'(seen), 1);
    chk("len0_latency_le2", int'(lat <= 2), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("len0_no_mem_valid", mv_cycles - mv0, 0);
    chk("len0_done_once", done_cnt - dn0, 1);
    chk("len0_idle", int'(busy_o), 0);

    // Command presented while busy is ignored, not queued.
    dly = 0; dn0 = done_cnt; al0 = addr_log.size();
    src_end = src_idx;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = 6'd40; cmd_len_i = 7'd2;
    @(posedge clk); #1;
    cmd_wr_i = 1'b0; cmd_addr_i = 6'd50; cmd_len_i = 7'd5;
    repeat (4) @(negedge clk);
    chk("busy_cmd_ready_low", int'(cmd_ready_o), 0);
    chk("busy_stalled_fetch", int'(s_ready_o), 1);
    cmd_valid_i = 1'b0;
    src_base = 16'h0400; src_off = src_idx; src_end = src_idx + 2;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = done_o;
    end
    chk("ignored_done_seen", int'(seen), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("ignored_req_count", addr_log.size() - al0, 2);
    chk("ignored_done_once", done_cnt - dn0, 1);
    chk("ignored_mem40", int'(mem[40]), 16'h0400);
    chk("ignored_mem41", int'(mem[41]), 16'h0401);
    chk("ignored_not_queued", int'(busy_o), 0);

    // Reset during the 3rd word of a len=8 write starting at 30.
    dly = 3; dn0 = done_cnt; al0 = addr_log.size();
    src_base = 16'h0300; src_off = src_idx; src_end = src_idx + 8;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b1; cmd_addr_i = 6'd30; cmd_len_i = 7'd8;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      seen = (addr_log.size() - al0 == 2) && mem_valid_o;
    end
    chk("rst_reached_word3", int'(seen), 1);
    chk("rst_word3_addr", int'(mem_addr_o), 32);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midburst_reset");
    src_end = src_idx;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt - dn0, 0);
    chk("rst_mem30", int'(mem[30]), 16'h0300);
    chk("rst_mem31", int'(mem[31]), 16'h0301);
    for (int a = 32; a < 38; a++)
      chk($sformatf("rst_untouched%0d", a), int'(mem[a]), 16'h0200 + a);
    chk("rst_stays_idle", int'(cmd_ready_o), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
